// File: rtl/rect_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rect_cmd_sequencer_pkg
// Shared definitions for the rectangle command sequencer:
//   - default queue depth and colour width
//   - coordinate/size field width and packed command payload layout
//   - sequencer FSM state encoding
//   - helper that flags commands with a zero dimension
// -----------------------------------------------------------------------------
package rect_cmd_sequencer_pkg;

   localparam int FIFO_DEPTH_DEFAULT = 4;
   localparam int COLOUR_W_DEFAULT   = 3;
   localparam int COORD_W            = 8;

   // Payload layout, LSB first: x, y, w, h, then colour above GEOM_W.
   localparam int GEOM_W = 4 * COORD_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_DRAW    = 2'd2,
      ST_RELEASE = 2'd3
   } seq_state_t;

   // The rasteriser counts until it reaches width/height, so a zero
   // dimension would never finish; such commands are dropped instead.
   function automatic logic is_degenerate(input logic [COORD_W-1:0] w,
                                          input logic [COORD_W-1:0] h);
      return (w == '0) || (h == '0);
   endfunction

endpackage

// File: rtl/rect_cmd_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// rect_cmd_fifo
// Synchronous first-word-fall-through FIFO holding packed draw commands.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, push_data write request and payload (ignored when full)
//   pop             remove the head entry (ignored when empty)
//   head_data       current head entry, valid whenever empty is low
//   count           number of stored entries (0..DEPTH)
//   full, empty     status flags derived from count
// -----------------------------------------------------------------------------
module rect_cmd_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 35,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign count   = count_reg;

   // Head must be visible in the same cycle the sequencer pops it, so the
   // read is asynchronous; the queue is tiny and maps to distributed RAM.
   assign head_data = mem[rd_ptr_reg];

   // Storage has no reset: stale entries are never read because empty gates pops.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/rect_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// rect_cmd_sequencer
// Queues rectangle draw commands and issues them one at a time to the
// rectangle rasteriser, generating the colour and plot strobe for the VGA
// adapter.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   cmd_valid/cmd_ready                 command handshake (transfer when both high)
//   cmd_x/cmd_y/cmd_w/cmd_h/cmd_colour  command origin, size and fill colour
//   rect_start_x/y, rect_width/height   geometry of the rectangle being drawn
//   rect_enable                         rasteriser enable
//   rect_finished                       rasteriser finished_draw
//   colour_out                          colour of the current rectangle
//   plot                                VGA write strobe for the rasteriser x/y
//   busy                                high unless idle with an empty queue
//   queue_count                         commands currently buffered
// -----------------------------------------------------------------------------
module rect_cmd_sequencer
   import rect_cmd_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int COLOUR_W   = COLOUR_W_DEFAULT
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [7:0]                  cmd_x,
   input  logic [7:0]                  cmd_y,
   input  logic [7:0]                  cmd_w,
   input  logic [7:0]                  cmd_h,
   input  logic [COLOUR_W-1:0]         cmd_colour,
   output logic [7:0]                  rect_start_x,
   output logic [7:0]                  rect_start_y,
   output logic [7:0]                  rect_width,
   output logic [7:0]                  rect_height,
   output logic                        rect_enable,
   input  logic                        rect_finished,
   output logic [COLOUR_W-1:0]         colour_out,
   output logic                        plot,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] queue_count
);

   localparam int PAYLOAD_W = GEOM_W + COLOUR_W;

   seq_state_t             state_reg;
   logic [PAYLOAD_W-1:0]   push_payload;
   logic [PAYLOAD_W-1:0]   head_payload;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;
   logic [COORD_W-1:0]     head_x;
   logic [COORD_W-1:0]     head_y;
   logic [COORD_W-1:0]     head_w;
   logic [COORD_W-1:0]     head_h;
   logic [COLOUR_W-1:0]    head_colour;

   // Ready depends only on the registered count, so a push against a full
   // queue waits one cycle even if the sequencer pops on that same edge.
   assign cmd_ready    = ~fifo_full;
   assign push         = cmd_valid & cmd_ready;
   assign pop          = (state_reg == ST_LOAD);
   assign push_payload = {cmd_colour, cmd_h, cmd_w, cmd_y, cmd_x};

   assign head_x      = head_payload[0*COORD_W +: COORD_W];
   assign head_y      = head_payload[1*COORD_W +: COORD_W];
   assign head_w      = head_payload[2*COORD_W +: COORD_W];
   assign head_h      = head_payload[3*COORD_W +: COORD_W];
   assign head_colour = head_payload[GEOM_W +: COLOUR_W];

   rect_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PAYLOAD_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_payload),
      .pop       (pop),
      .head_data (head_payload),
      .count     (queue_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         rect_start_x <= '0;
         rect_start_y <= '0;
         rect_width   <= '0;
         rect_height  <= '0;
         colour_out   <= '0;
         rect_enable  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state_reg <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               // Geometry and colour are captured here and stay frozen
               // until the next LOAD, so they are stable throughout DRAW.
               rect_start_x <= head_x;
               rect_start_y <= head_y;
               rect_width   <= head_w;
               rect_height  <= head_h;
               colour_out   <= head_colour;
               if (is_degenerate(head_w, head_h)) begin
                  state_reg <= ST_IDLE;
               end else begin
                  state_reg   <= ST_DRAW;
                  rect_enable <= 1'b1;
               end
            end
            ST_DRAW: begin
               if (rect_finished) begin
                  state_reg   <= ST_RELEASE;
                  rect_enable <= 1'b0;
               end
            end
            ST_RELEASE: begin
               // One cycle with enable low lets the rasteriser clear its
               // counters and finished flag before the next rectangle.
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg   <= ST_IDLE;
               rect_enable <= 1'b0;
            end
         endcase
      end
   end

   // Suppressing plot while finished is high avoids repeating the last pixel.
   assign plot = (state_reg == ST_DRAW) & rect_enable & ~rect_finished;
   assign busy = (state_reg != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_rect_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rect_cmd_sequencer
// Directed stimulus with a scoreboard: accepted commands push their expected
// rectangle and pixel list; a negedge monitor, driven by a behavioural
// rasteriser model, pops and compares on every enable pulse and plot strobe.
// -----------------------------------------------------------------------------
module tb_rect_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
   logic [2:0] cmd_colour = '0;
   logic [7:0] rect_start_x, rect_start_y, rect_width, rect_height;
   logic       rect_enable;
   logic       rect_finished;
   logic [2:0] colour_out;
   logic       plot;
   logic       busy;
   logic [2:0] queue_count;

   always #5 clk = ~clk;

   rect_cmd_sequencer #(
      .FIFO_DEPTH (4),
      .COLOUR_W   (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_x         (cmd_x),
      .cmd_y         (cmd_y),
      .cmd_w         (cmd_w),
      .cmd_h         (cmd_h),
      .cmd_colour    (cmd_colour),
      .rect_start_x  (rect_start_x),
      .rect_start_y  (rect_start_y),
      .rect_width    (rect_width),
      .rect_height   (rect_height),
      .rect_enable   (rect_enable),
      .rect_finished (rect_finished),
      .colour_out    (colour_out),
      .plot          (plot),
      .busy          (busy),
      .queue_count   (queue_count)
   );

   // Behavioural rasteriser: scans x then y while enabled, raises finished
   // after the last pixel, and clears everything while enable is low.
   logic [7:0] rx = '0, ry = '0;
   logic       rfin = 1'b0;
   assign rect_finished = rfin;

   always @(posedge clk) begin
      if (!rect_enable) begin
         rx   <= '0;
         ry   <= '0;
         rfin <= 1'b0;
      end else if (!rfin) begin
         if (rx == rect_width - 8'd1) begin
            rx <= '0;
            if (ry == rect_height - 8'd1) rfin <= 1'b1;
            else ry <= ry + 8'd1;
         end else begin
            rx <= rx + 8'd1;
         end
      end
   end

   typedef struct {int x; int y; int w; int h; int c;} cmd_t;
   typedef struct {int x; int y; int c;} pix_t;

   cmd_t exp_cmd[$];
   pix_t exp_pix[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulses = 0;
   int   total_plots = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // ---------------- monitor ----------------
   cmd_t cur;
   logic prev_en = 1'b0;
   int   plots_in = 0;
   int   gap = 0;
   logic have_prev = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         prev_en   = 1'b0;
         have_prev = 1'b0;
         plots_in  = 0;
         gap       = 0;
      end else begin
         if (rect_enable && !prev_en) begin
            pulses++;
            plots_in = 0;
            if (have_prev) check("enable_gap", int'(gap >= 3), 1);
            if (exp_cmd.size() == 0) begin
               check("unexpected_enable", 1, 0);
               cur = '{x: -1, y: -1, w: 0, h: 0, c: -1};
            end else begin
               cur = exp_cmd.pop_front();
               check("rect_x", int'(rect_start_x), cur.x);
               check("rect_y", int'(rect_start_y), cur.y);
               check("rect_w", int'(rect_width), cur.w);
               check("rect_h", int'(rect_height), cur.h);
               check("colour", int'(colour_out), cur.c);
            end
         end else if (rect_enable) begin
            check("rect_hold", int'(int'(rect_start_x) == cur.x && int'(rect_start_y) == cur.y &&
                                    int'(rect_width) == cur.w && int'(rect_height) == cur.h &&
                                    int'(colour_out) == cur.c), 1);
         end
         if (plot) begin
            plots_in++;
            total_plots++;
            if (exp_pix.size() == 0) begin
               check("unexpected_plot", 1, 0);
            end else begin
               pix_t p;
               p = exp_pix.pop_front();
               check("plot_x", (int'(rect_start_x) + int'(rx)) & 255, p.x);
               check("plot_y", (int'(rect_start_y) + int'(ry)) & 255, p.y);
               check("plot_colour", int'(colour_out), p.c);
            end
         end
         if (!rect_enable && prev_en) begin
            check("plots_per_rect", plots_in, cur.w * cur.h);
            have_prev = 1'b1;
            gap = 1;
         end else if (!rect_enable) begin
            gap++;
         end
         prev_en = rect_enable;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_cmd(input int x, input int y, input int w, input int h, input int c);
      logic acc;
      int   guard;
      cmd_x      = 8'(x);
      cmd_y      = 8'(y);
      cmd_w      = 8'(w);
      cmd_h      = 8'(h);
      cmd_colour = 3'(c);
      cmd_valid  = 1'b1;
      guard      = 0;
      acc        = 1'b0;
      forever begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         guard++;
         if (guard > 300) begin
            check("push_timeout", 0, 1);
            break;
         end
      end
      cmd_valid = 1'b0;
      if (acc && w != 0 && h != 0) begin
         exp_cmd.push_back('{x: x, y: y, w: w, h: h, c: c});
         for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
               exp_pix.push_back('{x: (x + i) & 255, y: (y + j) & 255, c: c});
      end
      $display("push x=%0d y=%0d w=%0d h=%0d colour=%0d accepted=%0d waited=%0d",
               x, y, w, h, c, acc, guard);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int g = 0;
      while (busy && g < 1000) begin
         step();
         g++;
      end
      check({tag, "_idle"}, int'(busy), 0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int p0, n0, g;

      repeat (3) step();
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_rect_enable", int'(rect_enable), 0);
      check("rst_plot", int'(plot), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_queue_count", int'(queue_count), 0);
      check("rst_colour_out", int'(colour_out), 0);
      check("rst_rect_start_x", int'(rect_start_x), 0);
      reset = 1'b0;
      step();

      // Single command and latency
      $display("test single");
      p0 = total_plots; n0 = pulses;
      push_cmd(10, 20, 3, 2, 4);
      check("t1_count_after_push", int'(queue_count), 1);
      check("t1_busy_after_push", int'(busy), 1);
      check("t1_enable_edge1", int'(rect_enable), 0);
      step();
      check("t1_enable_edge2", int'(rect_enable), 0);
      step();
      check("t1_enable_edge3", int'(rect_enable), 1);
      g = 0;
      while (rect_enable && g < 100) begin step(); g++; end
      check("t1_enable_fell", int'(rect_enable), 0);
      check("t1_busy_in_release", int'(busy), 1);
      step();
      check("t1_busy_after_release", int'(busy), 0);
      check("t1_plots", total_plots - p0, 6);
      check("t1_pulses", pulses - n0, 1);

      // Fill the queue; the 6th push stalls across the LOAD pop of a full queue
      $display("test fill");
      p0 = total_plots; n0 = pulses;
      push_cmd(0, 0, 4, 1, 1);
      push_cmd(5, 5, 2, 1, 2);
      push_cmd(7, 3, 1, 2, 3);
      push_cmd(100, 50, 2, 2, 5);
      push_cmd(200, 1, 3, 1, 6);
      check("t2_count_full", int'(queue_count), 4);
      check("t2_ready_full", int'(cmd_ready), 0);
      push_cmd(9, 9, 1, 1, 7);
      check("t2_count_after_6th", int'(queue_count), 4);
      wait_idle("t2");
      check("t2_plots", total_plots - p0, 16);
      check("t2_pulses", pulses - n0, 6);

      // Zero-size command is discarded
      $display("test zero_size");
      p0 = total_plots; n0 = pulses;
      push_cmd(30, 40, 0, 5, 2);
      push_cmd(50, 60, 2, 2, 3);
      wait_idle("t3");
      check("t3_plots", total_plots - p0, 4);
      check("t3_pulses", pulses - n0, 1);

      // 1x1 at the coordinate limit
      $display("test corner");
      p0 = total_plots; n0 = pulses;
      push_cmd(255, 255, 1, 1, 5);
      wait_idle("t4");
      check("t4_plots", total_plots - p0, 1);
      check("t4_pulses", pulses - n0, 1);

      // Reset in the middle of an 8x8 draw with commands still queued
      $display("test reset_mid_draw");
      p0 = total_plots;
      push_cmd(0, 0, 8, 8, 2);
      push_cmd(1, 1, 1, 1, 1);
      push_cmd(2, 2, 2, 2, 3);
      g = 0;
      while (total_plots < p0 + 10 && g < 500) begin @(negedge clk); g++; end
      check("t5_reached_10_plots", int'(total_plots >= p0 + 10), 1);
      check("t5_queue_before_reset", int'(queue_count), 2);
      reset = 1'b1;
      step();
      check("t5_rect_enable", int'(rect_enable), 0);
      check("t5_plot", int'(plot), 0);
      check("t5_queue_count", int'(queue_count), 0);
      check("t5_cmd_ready", int'(cmd_ready), 1);
      check("t5_busy", int'(busy), 0);
      exp_cmd.delete();
      exp_pix.delete();
      step();
      reset = 1'b0;
      repeat (4) step();
      check("t5_no_restart", int'(rect_enable), 0);

      check("pix_left", exp_pix.size(), 0);
      check("cmd_left", exp_cmd.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
